// File: rtl/control_file_pkg.sv
// Shared opcode/function codes, control-line encodings and the packed control word
// for the KGP-RISC instruction decoder.
package control_file_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BLTZ  = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BZ    = 6'd4;
    localparam logic [5:0] OP_BNZ   = 6'd5;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_ADDI  = 6'd15;
    localparam logic [5:0] OP_SLTI  = 6'd16;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_SRA   = 6'd29;
    localparam logic [5:0] FN_SRL   = 6'd30;
    localparam logic [5:0] FN_SLL   = 6'd31;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_SLT   = 6'd42;

    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_R31 = 2'b10;

    localparam logic [1:0] ALU_IMM_RT   = 2'b00;
    localparam logic [1:0] ALU_IMM_SEXT = 2'b01;
    localparam logic [1:0] ALU_IMM_ZEXT = 2'b10;

    localparam logic [2:0] LOGIC_AND = 3'b000;
    localparam logic [2:0] LOGIC_OR  = 3'b001;
    localparam logic [2:0] LOGIC_XOR = 3'b010;
    localparam logic [2:0] LOGIC_SLL = 3'b100;
    localparam logic [2:0] LOGIC_SRL = 3'b101;
    localparam logic [2:0] LOGIC_SRA = 3'b110;

    localparam logic [1:0] REGIN_ALU = 2'b00;
    localparam logic [1:0] REGIN_MEM = 2'b01;
    localparam logic [1:0] REGIN_PC4 = 2'b10;
    localparam logic [1:0] REGIN_SLT = 2'b11;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQZ  = 3'b001;
    localparam logic [2:0] BR_NEZ  = 3'b010;
    localparam logic [2:0] BR_LTZ  = 3'b011;
    localparam logic [2:0] BR_UNC  = 3'b100;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP = 2'b01;
    localparam logic [1:0] PC_SEL_RS   = 2'b10;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       reg_write;
        logic [1:0] alu_imm;
        logic       fn;
        logic [2:0] logic_fn;
        logic       fn_class;
        logic       data_read;
        logic       data_write;
        logic [1:0] regin_data;
        logic [2:0] br_type;
        logic [1:0] pc_sel;
    } ctrl_word_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/function to control-word mapping. With CONTROL_FILE_ILLEGAL_DET_EN
// defined it also flags undefined opcodes and undefined R-type function values.
module control_decode
    import control_file_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] function_val,
`ifdef CONTROL_FILE_ILLEGAL_DET_EN
    output logic       illegal,
`endif
    output ctrl_word_t cw
);

    logic bad_code;

    always_comb begin
        cw       = '0;
        bad_code = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                cw.reg_dst   = REG_DST_RD;
                cw.reg_write = 1'b1;
                cw.alu_imm   = ALU_IMM_RT;
                case (function_val)
                    FN_ADD: cw.fn = 1'b0;
                    FN_SUB: cw.fn = 1'b1;
                    FN_SLT: begin
                        cw.fn         = 1'b1;
                        cw.regin_data = REGIN_SLT;
                    end
                    FN_AND: begin cw.fn_class = 1'b1; cw.logic_fn = LOGIC_AND; end
                    FN_OR:  begin cw.fn_class = 1'b1; cw.logic_fn = LOGIC_OR;  end
                    FN_XOR: begin cw.fn_class = 1'b1; cw.logic_fn = LOGIC_XOR; end
                    FN_SLL: begin cw.fn_class = 1'b1; cw.logic_fn = LOGIC_SLL; end
                    FN_SRL: begin cw.fn_class = 1'b1; cw.logic_fn = LOGIC_SRL; end
                    FN_SRA: begin cw.fn_class = 1'b1; cw.logic_fn = LOGIC_SRA; end
                    FN_JR: begin
                        cw.reg_dst   = REG_DST_RT;
                        cw.reg_write = 1'b0;
                        cw.br_type   = BR_UNC;
                        cw.pc_sel    = PC_SEL_RS;
                    end
                    default: begin
                        // Undefined function: drop the shared R-type settings too.
                        cw       = '0;
                        bad_code = 1'b1;
                    end
                endcase
            end
            OP_ANDI: begin
                cw.reg_write = 1'b1;
                cw.alu_imm   = ALU_IMM_ZEXT;
                cw.fn_class  = 1'b1;
                cw.logic_fn  = LOGIC_AND;
            end
            OP_ORI: begin
                cw.reg_write = 1'b1;
                cw.alu_imm   = ALU_IMM_ZEXT;
                cw.fn_class  = 1'b1;
                cw.logic_fn  = LOGIC_OR;
            end
            OP_ADDI: begin
                cw.reg_write = 1'b1;
                cw.alu_imm   = ALU_IMM_SEXT;
            end
            OP_SLTI: begin
                cw.reg_write  = 1'b1;
                cw.alu_imm    = ALU_IMM_SEXT;
                cw.fn         = 1'b1;
                cw.regin_data = REGIN_SLT;
            end
            OP_LW: begin
                cw.reg_write  = 1'b1;
                cw.alu_imm    = ALU_IMM_SEXT;
                cw.data_read  = 1'b1;
                cw.regin_data = REGIN_MEM;
            end
            OP_SW: begin
                cw.alu_imm    = ALU_IMM_SEXT;
                cw.data_write = 1'b1;
            end
            OP_J: begin
                cw.br_type = BR_UNC;
                cw.pc_sel  = PC_SEL_JUMP;
            end
            OP_JAL: begin
                cw.reg_dst    = REG_DST_R31;
                cw.reg_write  = 1'b1;
                cw.regin_data = REGIN_PC4;
                cw.br_type    = BR_UNC;
                cw.pc_sel     = PC_SEL_JUMP;
            end
            OP_BLTZ: cw.br_type = BR_LTZ;
            OP_BZ:   cw.br_type = BR_EQZ;
            OP_BNZ:  cw.br_type = BR_NEZ;
            default: bad_code = 1'b1;
        endcase
    end

`ifdef CONTROL_FILE_ILLEGAL_DET_EN
    assign illegal = bad_code;
`else
    logic unused_bad_code;
    assign unused_bad_code = bad_code;
`endif

endmodule

// File: rtl/kgprisc_control_file.sv
// KGP-RISC main decoder: registers the control word one cycle after fetch.
// Optional illegal-code output enabled by CONTROL_FILE_ILLEGAL_DET_EN.
module kgprisc_control_file
    import control_file_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] function_val,
    output logic [1:0] reg_dst,
    output logic       reg_write,
    output logic [1:0] alu_imm,
    output logic       fn,
    output logic [2:0] logic_fn,
    output logic       fn_class,
    output logic       data_read,
    output logic       data_write,
    output logic [1:0] regin_data,
    output logic [2:0] br_type,
`ifdef CONTROL_FILE_ILLEGAL_DET_EN
    output logic       illegal,
`endif
    output logic [1:0] pc_sel
);

    ctrl_word_t cw_next;
    ctrl_word_t cw_q;

`ifdef CONTROL_FILE_ILLEGAL_DET_EN
    logic illegal_next;

    control_decode u_decode (
        .opcode       (opcode),
        .function_val (function_val),
        .illegal      (illegal_next),
        .cw           (cw_next)
    );

    always_ff @(posedge clk) begin
        if (rst) illegal <= 1'b0;
        else     illegal <= illegal_next;
    end
`else
    control_decode u_decode (
        .opcode       (opcode),
        .function_val (function_val),
        .cw           (cw_next)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) cw_q <= '0;
        else     cw_q <= cw_next;
    end

    assign reg_dst    = cw_q.reg_dst;
    assign reg_write  = cw_q.reg_write;
    assign alu_imm    = cw_q.alu_imm;
    assign fn         = cw_q.fn;
    assign logic_fn   = cw_q.logic_fn;
    assign fn_class   = cw_q.fn_class;
    assign data_read  = cw_q.data_read;
    assign data_write = cw_q.data_write;
    assign regin_data = cw_q.regin_data;
    assign br_type    = cw_q.br_type;
    assign pc_sel     = cw_q.pc_sel;

endmodule

// File: tb/tb_kgprisc_control_file.sv
// Directed bench for kgprisc_control_file; checks the full registered control word
// (and illegal when CONTROL_FILE_ILLEGAL_DET_EN is defined) one cycle after each input.
module tb_kgprisc_control_file;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] function_val;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] alu_imm;
    logic       fn;
    logic [2:0] logic_fn;
    logic       fn_class;
    logic       data_read;
    logic       data_write;
    logic [1:0] regin_data;
    logic [2:0] br_type;
    logic [1:0] pc_sel;
`ifdef CONTROL_FILE_ILLEGAL_DET_EN
    logic       illegal;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    kgprisc_control_file dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .function_val (function_val),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_imm      (alu_imm),
        .fn           (fn),
        .logic_fn     (logic_fn),
        .fn_class     (fn_class),
        .data_read    (data_read),
        .data_write   (data_write),
        .regin_data   (regin_data),
        .br_type      (br_type),
`ifdef CONTROL_FILE_ILLEGAL_DET_EN
        .illegal      (illegal),
`endif
        .pc_sel       (pc_sel)
    );

    // Field order: reg_dst, reg_write, alu_imm, fn, logic_fn, fn_class,
    // data_read, data_write, regin_data, br_type, pc_sel.
    function automatic logic [18:0] w(input logic [1:0] rd, input logic rw,
                                      input logic [1:0] ai, input logic f,
                                      input logic [2:0] lf, input logic fc,
                                      input logic dr, input logic dw,
                                      input logic [1:0] rg, input logic [2:0] br,
                                      input logic [1:0] pc);
        return {rd, rw, ai, f, lf, fc, dr, dw, rg, br, pc};
    endfunction

    task automatic step(input string tag, input logic r, input logic [5:0] op,
                        input logic [5:0] fv, input logic [18:0] exp, input logic exp_ill);
        logic [18:0] obs;
        @(negedge clk);
        rst          = r;
        opcode       = op;
        function_val = fv;
        @(posedge clk);
        #1;
        obs = {reg_dst, reg_write, alu_imm, fn, logic_fn, fn_class,
               data_read, data_write, regin_data, br_type, pc_sel};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
`ifdef CONTROL_FILE_ILLEGAL_DET_EN
        n_checks++;
        assert (illegal === exp_ill) else begin
            n_fail++;
            $error("FAIL %s_illegal: observed %b expected %b", tag, illegal, exp_ill);
        end
`else
        if (exp_ill === 1'bx) $display("note: unexpected x flag in %s", tag);
`endif
    endtask

    localparam logic [18:0] NOP = 19'd0;

    initial begin
        rst = 1'b1; opcode = 6'd35; function_val = 6'd0;

        step("reset_lw",     1'b1, 6'd35, 6'd0,  NOP, 1'b0);
        step("reset_hold",   1'b1, 6'd35, 6'd0,  NOP, 1'b0);
        step("first_lw",     1'b0, 6'd35, 6'd0,  w(2'b00,1,2'b01,0,3'b000,0,1,0,2'b01,3'b000,2'b00), 1'b0);

        step("r_add",        1'b0, 6'd0,  6'd32, w(2'b01,1,2'b00,0,3'b000,0,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("r_sub",        1'b0, 6'd0,  6'd34, w(2'b01,1,2'b00,1,3'b000,0,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("r_slt",        1'b0, 6'd0,  6'd42, w(2'b01,1,2'b00,1,3'b000,0,0,0,2'b11,3'b000,2'b00), 1'b0);
        step("r_and",        1'b0, 6'd0,  6'd36, w(2'b01,1,2'b00,0,3'b000,1,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("r_or",         1'b0, 6'd0,  6'd37, w(2'b01,1,2'b00,0,3'b001,1,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("r_xor",        1'b0, 6'd0,  6'd38, w(2'b01,1,2'b00,0,3'b010,1,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("r_sll",        1'b0, 6'd0,  6'd31, w(2'b01,1,2'b00,0,3'b100,1,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("r_srl",        1'b0, 6'd0,  6'd30, w(2'b01,1,2'b00,0,3'b101,1,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("r_sra",        1'b0, 6'd0,  6'd29, w(2'b01,1,2'b00,0,3'b110,1,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("r_jr",         1'b0, 6'd0,  6'd8,  w(2'b00,0,2'b00,0,3'b000,0,0,0,2'b00,3'b100,2'b10), 1'b0);

        step("lw",           1'b0, 6'd35, 6'd63, w(2'b00,1,2'b01,0,3'b000,0,1,0,2'b01,3'b000,2'b00), 1'b0);
        step("sw",           1'b0, 6'd43, 6'd0,  w(2'b00,0,2'b01,0,3'b000,0,0,1,2'b00,3'b000,2'b00), 1'b0);

        step("j",            1'b0, 6'd2,  6'd0,  w(2'b00,0,2'b00,0,3'b000,0,0,0,2'b00,3'b100,2'b01), 1'b0);
        step("jal",          1'b0, 6'd3,  6'd0,  w(2'b10,1,2'b00,0,3'b000,0,0,0,2'b10,3'b100,2'b01), 1'b0);
        step("bltz",         1'b0, 6'd1,  6'd0,  w(2'b00,0,2'b00,0,3'b000,0,0,0,2'b00,3'b011,2'b00), 1'b0);
        step("bz",           1'b0, 6'd4,  6'd0,  w(2'b00,0,2'b00,0,3'b000,0,0,0,2'b00,3'b001,2'b00), 1'b0);
        step("bnz",          1'b0, 6'd5,  6'd0,  w(2'b00,0,2'b00,0,3'b000,0,0,0,2'b00,3'b010,2'b00), 1'b0);

        step("andi",         1'b0, 6'd12, 6'd0,  w(2'b00,1,2'b10,0,3'b000,1,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("ori",          1'b0, 6'd13, 6'd0,  w(2'b00,1,2'b10,0,3'b001,1,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("addi",         1'b0, 6'd15, 6'd0,  w(2'b00,1,2'b01,0,3'b000,0,0,0,2'b00,3'b000,2'b00), 1'b0);
        step("slti",         1'b0, 6'd16, 6'd0,  w(2'b00,1,2'b01,1,3'b000,0,0,0,2'b11,3'b000,2'b00), 1'b0);
        step("andi_fv8",     1'b0, 6'd12, 6'd8,  w(2'b00,1,2'b10,0,3'b000,1,0,0,2'b00,3'b000,2'b00), 1'b0);

        step("ill_fn63",     1'b0, 6'd0,  6'd63, NOP, 1'b1);
        step("ill_op63",     1'b0, 6'd63, 6'd0,  NOP, 1'b1);
        step("ill_fn0",      1'b0, 6'd0,  6'd0,  NOP, 1'b1);
        step("lw_after_ill", 1'b0, 6'd35, 6'd0,  w(2'b00,1,2'b01,0,3'b000,0,1,0,2'b01,3'b000,2'b00), 1'b0);

        step("mid_rst_jal",  1'b1, 6'd3,  6'd0,  NOP, 1'b0);
        step("after_rst_j",  1'b0, 6'd2,  6'd0,  w(2'b00,0,2'b00,0,3'b000,0,0,0,2'b00,3'b100,2'b01), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/kgprisc_control_file.md
# kgprisc_control_file

Main instruction decoder of the KGP-RISC datapath. It sits between instruction fetch and the register-file/ALU/memory/PC-select stages. It maps the 6-bit opcode and 6-bit R-type function field onto every datapath control line. Outputs are registered, so the decode for an instruction fetched in cycle N drives the datapath in cycle N+1.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- opcode  in  6  instruction bits [31:26].
- function_val  in  6  instruction bits [5:0]; used only when opcode is 0.
- reg_dst  out  2  destination register: 00 = rt, 01 = rd, 10 = r31.
- reg_write  out  1  register-file write enable.
- alu_imm  out  2  ALU B operand: 00 = rt, 01 = sign-extended imm16, 10 = zero-extended imm16.
- fn  out  1  adder operation: 0 = add, 1 = subtract.
- logic_fn  out  3  logic/shift operation: 000 = and, 001 = or, 010 = xor, 100 = sll, 101 = srl, 110 = sra.
- fn_class  out  1  result path: 0 = adder, 1 = logic/shift unit.
- data_read  out  1  data-memory read enable.
- data_write  out  1  data-memory write enable.
- regin_data  out  2  write-back source: 00 = ALU, 01 = memory, 10 = PC+4, 11 = set-less-than (adder sign bit, zero-extended).
- br_type  out  3  branch type: 000 = none, 001 = rs==0, 010 = rs!=0, 011 = rs<0, 100 = unconditional.
- pc_sel  out  2  next-PC source: 00 = PC+4 or branch target, 01 = jump target, 10 = rs.

## Operation
- Any output not listed for an instruction below is 0.
- R-type group (opcode 0) shares these settings: reg_dst=01, reg_write=1, alu_imm=00. The function value selects the rest:
  - 32 add: fn=0, fn_class=0.
  - 34 sub: fn=1, fn_class=0.
  - 42 slt: fn=1, fn_class=0, regin_data=11.
  - 36 and, 37 or, 38 xor: fn_class=1, logic_fn = 000 / 001 / 010 respectively.
  - 31 sll, 30 srl, 29 sra: fn_class=1, logic_fn = 100 / 101 / 110 respectively.
  - 8 jr: exception to the shared settings. reg_write=0, reg_dst=00, br_type=100, pc_sel=10.
- Opcode 12 andi: reg_write=1, alu_imm=10, fn_class=1, logic_fn=000.
- Opcode 13 ori: reg_write=1, alu_imm=10, fn_class=1, logic_fn=001.
- Opcode 15 addi: reg_write=1, alu_imm=01, fn=0.
- Opcode 16 slti: reg_write=1, alu_imm=01, fn=1, regin_data=11.
- Opcode 35 lw: reg_write=1, alu_imm=01, data_read=1, regin_data=01.
- Opcode 43 sw: alu_imm=01, data_write=1.
- Opcode 2 j: br_type=100, pc_sel=01.
- Opcode 3 jal: reg_dst=10, reg_write=1, regin_data=10, br_type=100, pc_sel=01.
- Opcode 1 bltz: br_type=011.
- Opcode 4 bz: br_type=001.
- Opcode 5 bnz: br_type=010.
- Any undefined opcode, or opcode 0 with an undefined function value, decodes to NOP (all outputs 0).
- function_val is ignored whenever opcode ≠ 0.

## Timing
- Outputs update one clk edge after their inputs are sampled. Latency is exactly 1 cycle and there is no handshake.
- A new decode is accepted every cycle.
- When rst=1 at a rising edge, all outputs become 0 (NOP), regardless of the inputs.
- When rst is held, outputs stay 0. On the first edge with rst=0, outputs take the decode of the inputs present at that edge.
- Asserting rst mid-stream discards the pending decode.

## Configuration
- Macro CONTROL_FILE_ILLEGAL_DET_EN.
  - When defined: an extra output illegal (1 bit, registered, reset 0) is 1 for any undefined opcode or undefined R-type function value. The other outputs still decode to NOP.
  - When undefined: the port is absent, and undefined codes silently decode to NOP.

## Structure
- Shared package control_file_pkg holds:
  - opcode and function localparams;
  - encoding constants for reg_dst, alu_imm, logic_fn, regin_data, br_type and pc_sel;
  - a packed control-word struct.
- One sub-module, control_decode: purely combinational opcode/function to control-word mapping. The top level registers its output with synchronous reset.

## Test plan
- Reset: assert rst with opcode=35 -> all outputs 0 on the following edge.
- R-type sweep, opcode=0:
  - function 32, 34, 42, 36, 31 and 8, each applied for one cycle.
  - Function 32 -> next cycle reg_dst=01, reg_write=1, fn=0, fn_class=0.
  - Function 42 -> next cycle fn=1, regin_data=11.
  - Function 31 -> next cycle fn_class=1, logic_fn=100.
  - Function 8 -> next cycle reg_write=0, br_type=100, pc_sel=10.
- Memory instructions:
  - opcode=35 -> alu_imm=01, data_read=1, regin_data=01, reg_write=1.
  - opcode=43 -> data_write=1, reg_write=0.
- Control flow:
  - opcode=2 -> pc_sel=01, br_type=100.
  - opcode=3 -> reg_dst=10, regin_data=10.
  - opcodes 1 / 4 / 5 -> br_type=011 / 001 / 010, with pc_sel=00.
- Immediates:
  - opcode=12 -> alu_imm=10, logic_fn=000.
  - opcode=13 -> alu_imm=10, logic_fn=001.
  - opcode=15 -> alu_imm=01, fn=0.
  - opcode=16 -> alu_imm=01, regin_data=11.
- Illegal codes:
  - opcode=0 with function_val=63, and separately opcode=63 -> all outputs 0.
  - With CONTROL_FILE_ILLEGAL_DET_EN defined, illegal=1 for both cases and illegal=0 for opcode=35.
